// File: rtl/pkt_fifo_pkg.sv
// ----------------------------------------------------------------------------
// pkt_fifo_pkg
//
// Purpose : Shared types and constants for the store-and-forward packet FIFO.
//           Holds the write-side FSM state encoding, the statistics counter
//           width and a saturating-increment helper used by the counters.
//
// Contents:
//   CNT_W       - width of the dropped/committed packet counters (16)
//   cnt_t       - counter type, CNT_W bits
//   wr_state_e  - write FSM states: WR_IDLE, WR_PKT, WR_DROP
//   sat_inc()   - increment that sticks at all-ones
// ----------------------------------------------------------------------------
package pkt_fifo_pkg;

    localparam int CNT_W = 16;

    typedef logic [CNT_W-1:0] cnt_t;

    // WR_IDLE : between packets, next beat starts a new packet
    // WR_PKT  : inside a packet that is still being stored
    // WR_DROP : inside a packet that overflowed; beats are discarded to eof
    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_PKT  = 2'd1,
        WR_DROP = 2'd2
    } wr_state_e;

    // Counters stop at all-ones rather than wrapping back to a small value.
    function automatic cnt_t sat_inc(input cnt_t c);
        return (c == '1) ? c : c + cnt_t'(1);
    endfunction

endpackage

// File: rtl/pkt_fifo_ram.sv
// ----------------------------------------------------------------------------
// pkt_fifo_ram
//
// Purpose : Simple dual-port RAM, DEPTH x WIDTH, one write port and one read
//           port on the same clock. The read is registered and the read
//           register only updates when rd_en is high, so the last word read
//           is held for as long as the consumer needs it.
//
// Ports:
//   clk      - clock for both ports
//   wr_en    - write strobe
//   wr_addr  - write address
//   wr_data  - write data
//   rd_en    - read strobe; rd_data updates on the following edge
//   rd_addr  - read address
//   rd_data  - registered read data, held while rd_en is low
// ----------------------------------------------------------------------------
module pkt_fifo_ram #(
    parameter  int WIDTH = 5,
    parameter  int DEPTH = 4096,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the storage array and its read register carry no reset; a reset
    // would stop the array mapping onto block RAM, and the read pipeline in
    // the parent tracks validity separately so stale contents are never used.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/pkt_fifo.sv
// ----------------------------------------------------------------------------
// pkt_fifo
//
// Purpose : Store-and-forward packet FIFO for a nibble/byte stream (e.g. MII
//           receive). Beats of a packet are written speculatively behind a
//           commit pointer; a packet becomes readable only once its eof beat
//           arrives with in_err low. Bad packets (in_err on eof) and packets
//           that overflow the storage are rolled back and counted as drops.
//           The write side never applies backpressure.
//
// Parameters:
//   DATA_W - beat data width in bits
//   DEPTH  - storage beats, power of two >= 16
//
// Ports:
//   clk      - single clock
//   rst      - asynchronous, active-high reset
//   in_vld   - write beat present
//   in_dat   - write beat data
//   in_eof   - write beat is last of its packet
//   in_err   - on an eof beat, marks the packet bad
//   out_vld  - read beat of a committed packet presented
//   out_dat  - read beat data
//   out_eof  - read beat is last of its packet
//   out_ack  - consumer accepts the beat when out_vld && out_ack
//   drop_cnt - dropped-packet count (saturating)
//   pkt_cnt  - committed-packet count (saturating)
//
// Build option:
//   PKT_FIFO_STATS_EN - when defined, drop_cnt/pkt_cnt are live counters;
//                       otherwise both outputs are tied to zero and no
//                       counter registers are built.
// ----------------------------------------------------------------------------
module pkt_fifo
    import pkt_fifo_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_vld,
    input  logic [DATA_W-1:0] in_dat,
    input  logic              in_eof,
    input  logic              in_err,
    output logic              out_vld,
    output logic [DATA_W-1:0] out_dat,
    output logic              out_eof,
    input  logic              out_ack,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic [CNT_W-1:0]  pkt_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    // One extra pointer bit distinguishes full from empty when the address
    // bits are equal; all pointer arithmetic wraps modulo 2*DEPTH.
    typedef logic [PW-1:0] ptr_t;

    // ------------------------------------------------------------------
    // Pointers and write-side state
    // ------------------------------------------------------------------
    ptr_t      wr_ptr;
    ptr_t      wr_ptr_nxt;
    ptr_t      commit_ptr;
    ptr_t      commit_ptr_nxt;
    ptr_t      rd_ptr;
    ptr_t      fill;
    wr_state_e state;
    wr_state_e state_nxt;
    logic      full;
    logic      rd_empty;
    logic      wr_en;

    // fill counts everything written but not yet pulled into the read
    // pipeline, including the uncommitted tail of the packet being stored.
    assign fill     = wr_ptr - rd_ptr;
    assign full     = (fill == ptr_t'(DEPTH));
    assign rd_empty = (rd_ptr == commit_ptr);

    // ------------------------------------------------------------------
    // Write FSM: next-state and pointer decisions
    // ------------------------------------------------------------------
    // NOTE: every signal driven here gets a default before any branch, so
    // no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_nxt      = state;
        wr_ptr_nxt     = wr_ptr;
        commit_ptr_nxt = commit_ptr;
        wr_en          = 1'b0;

        if (in_vld) begin
            case (state)
                WR_IDLE, WR_PKT: begin
                    if (full) begin
                        // No room for this beat: roll back the partial
                        // packet. An eof beat ends it here, otherwise the
                        // rest of the packet is swallowed in WR_DROP.
                        wr_ptr_nxt = commit_ptr;
                        state_nxt  = in_eof ? WR_IDLE : WR_DROP;
                    end else begin
                        wr_en = 1'b1;
                        if (!in_eof) begin
                            wr_ptr_nxt = wr_ptr + ptr_t'(1);
                            state_nxt  = WR_PKT;
                        end else if (in_err) begin
                            // Bad packet: forget everything since the last
                            // commit, including the beat just written.
                            wr_ptr_nxt = commit_ptr;
                            state_nxt  = WR_IDLE;
                        end else begin
                            // Good eof: publish the whole packet at once.
                            wr_ptr_nxt     = wr_ptr + ptr_t'(1);
                            commit_ptr_nxt = wr_ptr + ptr_t'(1);
                            state_nxt      = WR_IDLE;
                        end
                    end
                end
                WR_DROP: begin
                    if (in_eof) begin
                        state_nxt = WR_IDLE;
                    end
                end
                default: begin
                    state_nxt = WR_IDLE;
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours, matching hardware.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= WR_IDLE;
            wr_ptr     <= '0;
            commit_ptr <= '0;
        end else begin
            state      <= state_nxt;
            wr_ptr     <= wr_ptr_nxt;
            commit_ptr <= commit_ptr_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Storage: eof flag kept alongside each data beat
    // ------------------------------------------------------------------
    logic              rd_en;
    logic [DATA_W:0]   ram_q;

    pkt_fifo_ram #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data ({in_eof, in_dat}),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (ram_q)
    );

    // ------------------------------------------------------------------
    // Read pipeline
    //   stage 1: RAM read register (ram_q), valid flag ram_vld
    //   stage 2: output register (out_*), valid flag out_vld
    // Each stage accepts a new beat when it is empty or its current beat
    // moves on this cycle, which gives one beat per cycle with the output
    // frozen while out_ack is low. A newly committed packet reaches out_vld
    // two edges after the commit edge.
    // ------------------------------------------------------------------
    logic ram_vld;
    logic load_out;

    assign load_out = ram_vld && (!out_vld || out_ack);
    assign rd_en    = !rd_empty && (!ram_vld || load_out);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr  <= '0;
            ram_vld <= 1'b0;
            out_vld <= 1'b0;
            out_dat <= '0;
            out_eof <= 1'b0;
        end else begin
            if (rd_en) begin
                rd_ptr <= rd_ptr + ptr_t'(1);
            end

            if (rd_en) begin
                ram_vld <= 1'b1;
            end else if (load_out) begin
                ram_vld <= 1'b0;
            end

            if (load_out) begin
                out_vld <= 1'b1;
                out_eof <= ram_q[DATA_W];
                out_dat <= ram_q[DATA_W-1:0];
            end else if (out_ack) begin
                out_vld <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Packet statistics
    // ------------------------------------------------------------------
`ifdef PKT_FIFO_STATS_EN
    logic drop_inc;
    logic pkt_inc;
    cnt_t drop_q;
    cnt_t pkt_q;

    // A packet ends on its eof beat; it is dropped if it was already being
    // discarded, if there is no room for the eof beat, or if it is marked bad.
    assign drop_inc = in_vld && in_eof && ((state == WR_DROP) || full || in_err);
    assign pkt_inc  = in_vld && in_eof && (state != WR_DROP) && !full && !in_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_q <= '0;
            pkt_q  <= '0;
        end else begin
            if (drop_inc) begin
                drop_q <= sat_inc(drop_q);
            end
            if (pkt_inc) begin
                pkt_q <= sat_inc(pkt_q);
            end
        end
    end

    assign drop_cnt = drop_q;
    assign pkt_cnt  = pkt_q;
`else
    assign drop_cnt = '0;
    assign pkt_cnt  = '0;
`endif

endmodule

// File: doc/pkt_fifo.md
PKT_FIFO -- requirements
Module: pkt_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 4, meaning beat data width in bits (MII nibble default).
REQ-002 SHALL have parameter DEPTH, default 4096, meaning storage beats; a power of two >= 16.
REQ-003 SHALL have port clk, input, 1, the single clock for all logic.
REQ-004 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-005 SHALL have port in_vld, input, 1, meaning a write beat is present this cycle.
REQ-006 SHALL have port in_dat, input, DATA_W, meaning write beat data.
REQ-007 SHALL have port in_eof, input, 1, meaning the beat is the last of its packet.
REQ-008 SHALL have port in_err, input, 1, sampled only on eof beats; a set value marks the packet bad (e.g. CRC fail).
REQ-009 SHALL have port out_vld, output, 1, meaning a read beat of a committed packet is presented.
REQ-010 SHALL have port out_dat, output, DATA_W, meaning read beat data.
REQ-011 SHALL have port out_eof, output, 1, meaning the read beat is the last of its packet.
REQ-012 SHALL have port out_ack, input, 1; the beat transfers when out_vld && out_ack.
REQ-013 SHALL have port drop_cnt, output, 16, meaning the dropped-packet count.
REQ-014 SHALL have port pkt_cnt, output, 16, meaning the committed-packet count.

Function
REQ-015 SHALL be store-and-forward: no beat of a packet is visible on out_* until its eof beat is committed.
REQ-016 SHALL keep wr_ptr, commit_ptr and rd_ptr, each clog2(DEPTH)+1 bits wide and wrapping modulo 2*DEPTH.
REQ-017 SHALL declare the FIFO full when wr_ptr - rd_ptr == DEPTH, and empty-for-read when rd_ptr == commit_ptr.
REQ-018 SHALL implement a write FSM with states WR_IDLE, WR_PKT and WR_DROP.
REQ-019 SHALL, in WR_IDLE/WR_PKT, write each accepted beat and increment wr_ptr; a non-eof beat leads to WR_PKT.
REQ-020 SHALL, on an eof beat with in_err=0 and not full, set commit_ptr to wr_ptr+1, increment pkt_cnt and go to WR_IDLE.
REQ-021 SHALL, on an eof beat with in_err=1, restore wr_ptr to commit_ptr, increment drop_cnt and go to WR_IDLE.
REQ-022 SHALL, on any beat arriving while full, restore wr_ptr to commit_ptr and go to WR_DROP; if that beat is eof, it increments drop_cnt and goes to WR_IDLE instead.
REQ-023 SHALL, in WR_DROP, discard beats until eof, then increment drop_cnt and go to WR_IDLE.
REQ-024 SHALL make a single-beat packet (in_eof on the first beat) legal.
REQ-025 SHALL assert out_vld exactly 2 cycles after the edge sampling a committing eof beat when the FIFO was previously read-empty.
REQ-026 SHALL hold out_dat and out_eof stable while out_vld && !out_ack.
REQ-027 SHALL sustain one beat per cycle on both the write and read sides simultaneously.
REQ-028 SHALL saturate drop_cnt and pkt_cnt at 16'hFFFF.
REQ-029 SHALL have no input backpressure; the write side always accepts beats or drops them.

Reset
REQ-030 SHALL, on rst, asynchronously clear all pointers and both counters, clear out_vld, out_dat and out_eof to 0, and set the FSM to WR_IDLE.
REQ-031 SHALL discard a partial packet in flight at reset (no drop_cnt increment); beats arriving after release with no prior start form a new packet.

Configuration
REQ-032 SHALL, with PKT_FIFO_STATS_EN defined, implement drop_cnt and pkt_cnt as specified; without it, both outputs are tied to 0 and no counter registers exist.

Structure
REQ-033 SHALL place the write-FSM state enum and the counter width constant (16) in the shared package pkt_fifo_pkg.
REQ-034 SHALL instantiate storage as sub-module pkt_fifo_ram: a simple dual-port RAM, DEPTH x (DATA_W+1), with registered read; the eof bit is stored alongside the data.

Verification
REQ-035 SHALL cover: a 5-beat packet 1,2,3,4,5 (eof on 5), err=0, out_ack=1 -> out_vld 2 cycles after eof; 1..5 read in order, out_eof on 5; pkt_cnt=1.
REQ-036 SHALL cover: a 3-beat packet with in_err=1 on eof, then a 2-beat good packet -> only the 2-beat packet is output; drop_cnt=1, pkt_cnt=1.
REQ-037 SHALL cover: DEPTH=16, out_ack=0, a 10-beat good packet, then a 10-beat packet -> the second overflows; out_* carries only the first 10 beats; drop_cnt=1.
REQ-038 SHALL cover: out_ack toggled randomly during a 4-beat packet -> data is held while unacked; no loss or duplication.
REQ-039 SHALL cover: rst pulsed mid-packet (beat 3 of 6) -> out_vld=0, counters=0; a following 2-beat packet is read intact.
REQ-040 SHALL cover: build without PKT_FIFO_STATS_EN -> drop_cnt and pkt_cnt read 0 after scenario REQ-036.
